// File: rtl/tty_kbd_pkg.sv
// -----------------------------------------------------------------------------
// tty_kbd_pkg
// Shared definitions for the TTY keyboard input path: PS/2 receiver state
// encodings, set-2 scancode constants and the ASCII control codes the decoder
// produces.
// -----------------------------------------------------------------------------
package tty_kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;

   localparam logic [7:0] ASCII_CR  = 8'h0d;
   localparam logic [7:0] ASCII_BS  = 8'h08;

   function automatic logic is_shift_code(input logic [7:0] sc);
      return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
   endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// -----------------------------------------------------------------------------
// scancode_to_ascii
// Combinational ROM: {shift, set-2 make code} -> ASCII, US layout.
// Returns 8'h00 for codes with no printable mapping.
//
// Ports
//   shift_i     in   1  shift key currently held
//   scancode_i  in   8  set-2 make code
//   ascii_o     out  8  ASCII character, 0 when unmapped
// -----------------------------------------------------------------------------
module scancode_to_ascii
   import tty_kbd_pkg::*;
(
   input  logic       shift_i,
   input  logic [7:0] scancode_i,
   output logic [7:0] ascii_o
);

   // Each entry holds {unshifted, shifted} as a two-character string.
   logic [15:0] pair;

   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      pair = 16'h0000;
      case (scancode_i)
         8'h1C: pair = "aA";  8'h32: pair = "bB";  8'h21: pair = "cC";  8'h23: pair = "dD";
         8'h24: pair = "eE";  8'h2B: pair = "fF";  8'h34: pair = "gG";  8'h33: pair = "hH";
         8'h43: pair = "iI";  8'h3B: pair = "jJ";  8'h42: pair = "kK";  8'h4B: pair = "lL";
         8'h3A: pair = "mM";  8'h31: pair = "nN";  8'h44: pair = "oO";  8'h4D: pair = "pP";
         8'h15: pair = "qQ";  8'h2D: pair = "rR";  8'h1B: pair = "sS";  8'h2C: pair = "tT";
         8'h3C: pair = "uU";  8'h2A: pair = "vV";  8'h1D: pair = "wW";  8'h22: pair = "xX";
         8'h35: pair = "yY";  8'h1A: pair = "zZ";
         8'h16: pair = "1!";  8'h1E: pair = "2@";  8'h26: pair = "3#";  8'h25: pair = "4$";
         8'h2E: pair = "5%";  8'h36: pair = "6^";  8'h3D: pair = "7&";  8'h3E: pair = "8*";
         8'h46: pair = "9(";  8'h45: pair = "0)";
         8'h0E: pair = "`~";  8'h4E: pair = "-_";  8'h55: pair = "=+";  8'h54: pair = "[{";
         8'h5B: pair = "]}";  8'h5D: pair = {8'h5C, "|"};  8'h4C: pair = ";:";
         8'h52: pair = {8'h27, 8'h22};
         8'h41: pair = ",<";  8'h49: pair = ".>";  8'h4A: pair = "/?";
         8'h29:    pair = "  ";
         SC_ENTER: pair = {ASCII_CR, ASCII_CR};
         SC_BKSP:  pair = {ASCII_BS, ASCII_BS};
         default:  pair = 16'h0000;
      endcase
   end

   assign ascii_o = shift_i ? pair[7:0] : pair[15:8];

endmodule

// File: rtl/tty_keyboard.sv
// -----------------------------------------------------------------------------
// tty_keyboard
// Input half of the TTY. Receives PS/2 set-2 frames, decodes make codes into
// ASCII while tracking shift, queues characters in a FIFO and hands them to the
// CPU through a read strobe on Memread.
//
// Parameters
//   FIFO_DEPTH      character FIFO entries (power of two, 2..64)
//   TIMEOUT_CYCLES  clocks without a PS/2 falling edge before a frame is dropped
//
// Ports
//   clk_50mhz  in   1  sole clock
//   rst        in   1  asynchronous active-high reset
//   ps2_clk    in   1  raw keyboard clock (asynchronous)
//   ps2_data   in   1  raw keyboard data (asynchronous)
//   Memread    in   1  CPU read request level; each rising edge pops one char
//   BUS        out 32  {24'h0, head character}, 0 when empty
//   ttyready   out  1  FIFO non-empty
//   overflow   out  1  sticky: a character was dropped on a full FIFO
//   frame_err  out  1  one-cycle pulse on a bad stop/parity bit or timeout
//
// Build option
//   KBD_PARITY_CHECK_EN  when defined, odd parity is enforced in the stop state;
//                        otherwise the parity bit is sampled and ignored.
// -----------------------------------------------------------------------------
module tty_keyboard
   import tty_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk_50mhz,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        Memread,
   output logic [31:0] BUS,
   output logic        ttyready,
   output logic        overflow,
   output logic        frame_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   // ---------------------------------------------------------------- sync
   // ps2_clk_q[1:0] is the synchronizer, ps2_clk_q[2] the edge register.
   logic [2:0] ps2_clk_q;
   logic [1:0] ps2_data_q;
   logic       sample_stb;
   logic       rx_bit;

   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         ps2_clk_q  <= 3'b111;
         ps2_data_q <= 2'b11;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         ps2_clk_q  <= {ps2_clk_q[1:0], ps2_clk};
         ps2_data_q <= {ps2_data_q[0], ps2_data};
      end
   end

   assign sample_stb = ps2_clk_q[2] & ~ps2_clk_q[1];
   assign rx_bit     = ps2_data_q[1];

   // ------------------------------------------------------------ receiver
   rx_state_e       state_q;
   logic [7:0]      data_sr_q;
   logic [2:0]      bit_cnt_q;
   logic [TO_W-1:0] to_cnt_q;
   logic            byte_valid_q;
   logic [7:0]      rx_byte_q;
   logic            frame_err_q;
   logic            stop_ok;

`ifdef KBD_PARITY_CHECK_EN
   logic parity_q;
   // Odd parity: data plus parity bit must carry an odd number of ones.
   assign stop_ok = rx_bit & (^{data_sr_q, parity_q});
`else
   assign stop_ok = rx_bit;
`endif

   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         data_sr_q    <= '0;
         bit_cnt_q    <= '0;
         to_cnt_q     <= '0;
         byte_valid_q <= 1'b0;
         rx_byte_q    <= '0;
         frame_err_q  <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;

         if (state_q == ST_IDLE || sample_stb) to_cnt_q <= '0;
         else                                  to_cnt_q <= to_cnt_q + 1'b1;

         if (state_q != ST_IDLE && !sample_stb && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Keyboard stalled mid-frame: abandon it and realign on the next start bit.
            state_q     <= ST_IDLE;
            frame_err_q <= 1'b1;
         end else if (sample_stb) begin
            case (state_q)
               ST_IDLE: begin
                  if (!rx_bit) begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               ST_DATA: begin
                  data_sr_q <= {rx_bit, data_sr_q[7:1]};   // LSB arrives first
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
               end
               ST_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
                  parity_q <= rx_bit;
`endif
                  state_q  <= ST_STOP;
               end
               ST_STOP: begin
                  state_q <= ST_IDLE;
                  if (stop_ok) begin
                     byte_valid_q <= 1'b1;
                     rx_byte_q    <= data_sr_q;
                  end else begin
                     frame_err_q  <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // ------------------------------------------------------------- decoder
   logic       brk_q;
   logic       ext_q;
   logic       shift_q;
   logic [7:0] rom_ascii;
   logic       is_prefix;
   logic       push_req;

   scancode_to_ascii u_rom (
      .shift_i    (shift_q),
      .scancode_i (rx_byte_q),
      .ascii_o    (rom_ascii)
   );

   assign is_prefix = (rx_byte_q == SC_BREAK) || (rx_byte_q == SC_EXT);
   assign push_req  = byte_valid_q && !is_prefix && !brk_q && !ext_q &&
                      !is_shift_code(rx_byte_q) && (rom_ascii != 8'h00);

   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         brk_q   <= 1'b0;
         ext_q   <= 1'b0;
         shift_q <= 1'b0;
      end else if (byte_valid_q) begin
         if (rx_byte_q == SC_BREAK) begin
            brk_q <= 1'b1;
         end else if (rx_byte_q == SC_EXT) begin
            ext_q <= 1'b1;
         end else begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
            if (brk_q) begin
               if (is_shift_code(rx_byte_q)) shift_q <= 1'b0;
            end else if (!ext_q && is_shift_code(rx_byte_q)) begin
               shift_q <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;
   logic             rd_flag_q;
   logic [7:0]       head_q;
   logic             ttyready_q;
   logic             full;
   logic             pop_req;
   logic             pop_ok;
   logic             push_ok;
   logic [CNT_W-1:0] count_after_pop;
   logic [PTR_W-1:0] head_idx;

   // Memread is driven from this clock domain, so it is edge-detected directly.
   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop_req  = Memread & ~rd_flag_q;
   assign pop_ok   = pop_req & (count_q != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_ok  = push_req & (~full | pop_ok);

   // The output register looks past this cycle's pop so BUS advances on the
   // cycle after the read edge; pushes show up one cycle after they land.
   assign count_after_pop = count_q - CNT_W'(pop_ok);
   assign head_idx        = rd_ptr_q + PTR_W'(pop_ok);

   // NOTE: storage array has no reset; only pointers and count define validity.
   always_ff @(posedge clk_50mhz) begin
      if (push_ok) mem_q[wr_ptr_q] <= rom_ascii;
   end

   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_flag_q  <= 1'b0;
         head_q     <= 8'h00;
         ttyready_q <= 1'b0;
      end else begin
         rd_flag_q <= Memread;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
         if (push_req && !push_ok) overflow_q <= 1'b1;
         ttyready_q <= (count_after_pop != '0);
         head_q     <= (count_after_pop != '0) ? mem_q[head_idx] : 8'h00;
      end
   end

   assign BUS       = {24'h0, head_q};
   assign ttyready  = ttyready_q;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tty_keyboard.sv
// -----------------------------------------------------------------------------
// tb_tty_keyboard
// Drives PS/2 frames into tty_keyboard and compares BUS/ttyready/overflow and
// frame_err pulses against a queue-based model of the keyboard decoder.
// -----------------------------------------------------------------------------
module tb_tty_keyboard;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 2000;
   localparam int HALF    = 20;     // clk cycles per PS/2 clock half period

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2_clk;
   logic        ps2_data;
   logic        memread;
   logic [31:0] bus;
   logic        ttyready;
   logic        overflow;
   logic        frame_err;

   tty_keyboard #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk_50mhz (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .Memread   (memread),
      .BUS       (bus),
      .ttyready  (ttyready),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------ model
   localparam logic [7:0] KEY_CODES [48] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
      8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
      8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
      8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
      8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A,
      8'h29
   };
   string key_lo = "abcdefghijklmnopqrstuvwxyz1234567890`-=[]#;#,./ ";
   string key_hi = "ABCDEFGHIJKLMNOPQRSTUVWXYZ!@#$%^&*()~_+{}|:#<>? ";

   logic [7:0] q [$];
   bit m_shift = 0, m_brk = 0, m_ext = 0, m_ovf = 0;
   int ferr_seen = 0;
   int ferr_exp  = 0;

   always @(negedge clk) if (frame_err === 1'b1) ferr_seen++;

   function automatic logic [7:0] model_ascii(input logic [7:0] sc, input bit sh);
      if (sc == 8'h5A) return 8'h0d;
      if (sc == 8'h66) return 8'h08;
      if (sc == 8'h5D) return sh ? 8'h7C : 8'h5C;
      if (sc == 8'h52) return sh ? 8'h22 : 8'h27;
      for (int i = 0; i < 48; i++)
         if (KEY_CODES[i] == sc) return sh ? key_hi[i] : key_lo[i];
      return 8'h00;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] c;
      bit is_sh;
      is_sh = (b == 8'h12) || (b == 8'h59);
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else begin
         if (m_brk) begin
            if (is_sh) m_shift = 0;
         end else if (!m_ext) begin
            if (is_sh) m_shift = 1;
            else begin
               c = model_ascii(b, m_shift);
               if (c != 8'h00) begin
                  if (q.size() < DEPTH) q.push_back(c);
                  else m_ovf = 1;
               end
            end
         end
         m_brk = 0;
         m_ext = 0;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_rdy"}, {31'h0, ttyready}, {31'h0, q.size() != 0});
      check({tag, "_bus"}, bus, (q.size() != 0) ? {24'h0, q[0]} : 32'h0);
      check({tag, "_ovf"}, {31'h0, overflow}, {31'h0, m_ovf});
   endtask

   // ------------------------------------------------------------ PS/2 drivers
   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // Start bit, data LSB first, odd parity (optionally inverted); no stop bit.
   task automatic send_head(input logic [7:0] b, input bit bad_parity);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_parity);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_head(b, 1'b0);
      ps2_bit(1'b1);
      repeat (HALF) @(negedge clk);
      model_byte(b);
   endtask

   task automatic pop_pulse();
      memread = 1'b1;
      @(negedge clk);
      memread = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      @(negedge clk);
   endtask

   initial begin
      #1_800_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [7:0] b;
      logic [7:0] sc;

      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; memread = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_bus", bus, 32'h0);
      check("reset_rdy", {31'h0, ttyready}, 32'h0);
      check("reset_ovf", {31'h0, overflow}, 32'h0);
      check("reset_ferr", {31'h0, frame_err}, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 'a' with exact output latency after the stop-bit falling edge.
      sc = 8'h1C;
      send_head(sc, 1'b0);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (4) @(negedge clk);
      check("lat_before", {31'h0, ttyready}, 32'h0);
      @(negedge clk);
      check("lat_rdy", {31'h0, ttyready}, 32'h1);
      check("lat_bus", bus, 32'h61);
      repeat (HALF - 5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      model_byte(sc);
      check_model("a_key");
      memread = 1'b1;
      @(negedge clk);
      check("pop_bus", bus, 32'h0);
      check("pop_rdy", {31'h0, ttyready}, 32'h0);
      memread = 1'b0;
      void'(q.pop_front());
      @(negedge clk);

      // Shift make/break handling.
      send_byte(8'h12); send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h12);
      send_byte(8'h1C);
      check("shift_first", bus, 32'h41);
      check_model("shift");
      pop_pulse();
      check("shift_second", bus, 32'h61);
      check_model("shift_pop1");
      pop_pulse();
      check_model("shift_pop2");

      // Enter, ignored extended key, then a held read.
      send_byte(8'h5A); send_byte(8'hE0); send_byte(8'h75); send_byte(8'h1C);
      check("enter_bus", bus, 32'h0d);
      memread = 1'b1;
      repeat (10) @(negedge clk);
      memread = 1'b0;
      @(negedge clk);
      void'(q.pop_front());
      check("held_read", bus, 32'h61);
      check_model("held");
      pop_pulse();
      check_model("held_drain");

      // Overflow: DEPTH+1 presses of '1'.
      for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h16);
      check("ovf_flag", {31'h0, overflow}, 32'h1);
      check("ovf_bus", bus, 32'h31);
      check_model("ovf");

      // Push of '2' lands on the same edge as a pop while full.
      sc = 8'h1E;
      send_head(sc, 1'b0);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      memread = 1'b1;
      @(negedge clk);
      memread = 1'b0;
      repeat (HALF - 4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      void'(q.pop_front());
      model_byte(sc);
      check("simul_count", q.size(), DEPTH);
      check_model("simul");
      for (int i = 0; i < DEPTH; i++) begin
         pop_pulse();
         check_model("drain");
      end

      // Corrupted parity bit.
      send_head(8'h1C, 1'b1);
      ps2_bit(1'b1);
      repeat (HALF) @(negedge clk);
`ifdef KBD_PARITY_CHECK_EN
      ferr_exp++;
`else
      model_byte(8'h1C);
`endif
      check("parity_ferr", ferr_seen, ferr_exp);
      check_model("parity");
      if (q.size() != 0) begin
         pop_pulse();
         check_model("parity_pop");
      end

      // Stall after four data bits, then recover.
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
      repeat (TIMEOUT + 200) @(negedge clk);
      ferr_exp++;
      check("timeout_ferr", ferr_seen, ferr_exp);
      send_byte(8'h1C);
      check("timeout_recover", bus, 32'h61);
      check_model("timeout");

      // Reset mid-frame with a non-empty FIFO.
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
      rst = 1'b1;
      #1;
      check("rst_bus", bus, 32'h0);
      check("rst_rdy", {31'h0, ttyready}, 32'h0);
      check("rst_ovf", {31'h0, overflow}, 32'h0);
      check("rst_ferr", {31'h0, frame_err}, 32'h0);
      q.delete();
      m_shift = 0; m_brk = 0; m_ext = 0; m_ovf = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_byte(8'h2D);
      check_model("after_rst");

      // Randomized key traffic with interleaved reads.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0:       b = 8'hF0;
            1:       b = 8'hE0;
            2:       b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            3:       b = 8'($urandom);
            4:       b = ($urandom_range(0, 1) != 0) ? 8'h5A : 8'h66;
            default: b = KEY_CODES[$urandom_range(0, 47)];
         endcase
         send_byte(b);
         check_model("rnd");
         if ($urandom_range(0, 2) == 0) begin
            pop_pulse();
            check_model("rnd_pop");
         end
      end

      check("final_ferr", ferr_seen, ferr_exp);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
